ama_riscv_dmem_arbiter: RTL and testbench

Shares the single-port, synchronous-read data memory between the core MEM stage and a host/debug access port. The core has priority. A saturating wait counter guarantees the host a slot after at most `HOST_MAX_WAIT` contended cycles, and the arbiter stalls the core for that one cycle. The block sits between the core's load/store path (driven by the decoder's `dmem_en`/`store_inst` controls) and the DMEM macro.

---
 rtl/ama_riscv_dmem_arbiter_pkg.sv | 21 ++
 rtl/ama_riscv_arb_wait_cnt.sv | 28 ++
 rtl/ama_riscv_dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_ama_riscv_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ama_riscv_dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   ARB_SEL_CORE / ARB_SEL_HOST : memory-port select encodings
//   ARB_HOST_MAX_WAIT_DEF       : default contended-cycle budget before the host is forced in
//   ARB_HOST_EN                 : mirrors the AMA_RISCV_DMEM_ARB_HOST_EN build macro
//                                 (the macro lives with the ALU/WB select defines)
package ama_riscv_dmem_arbiter_pkg;

    typedef enum logic {
        ARB_SEL_CORE = 1'b0,
        ARB_SEL_HOST = 1'b1
    } arb_sel_t;

    localparam int ARB_HOST_MAX_WAIT_DEF = 8;

`ifdef AMA_RISCV_DMEM_ARB_HOST_EN
    localparam bit ARB_HOST_EN = 1'b1;
`else
    localparam bit ARB_HOST_EN = 1'b0;
`endif

endpackage

// File: rtl/ama_riscv_arb_wait_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Sized for reuse by other arbiters (e.g. an IMEM loader port).
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one more contended cycle (holds once cnt == MAX)
//   clr        : return to zero
//   cnt        : current count, never exceeds MAX
module ama_riscv_arb_wait_cnt #(
    parameter int W   = 8,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/ama_riscv_dmem_arbiter.sv
// Arbitrates the single-port synchronous-read DMEM between the core MEM stage
// (priority) and a host/debug port. A wait counter forces one host slot after
// HOST_MAX_WAIT contended cycles, stalling the core for that cycle.
// Build option: AMA_RISCV_DMEM_ARB_HOST_EN. Undefined -> host port is inert and
// the memory port is a straight core pass-through plus the read-return flag.
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   core_req/we/addr/wdata/wmask      : core access, issued combinationally
//   core_rdata, core_stall            : load data (cycle after issue), hold request
//   host_req/we/addr/wdata/wmask      : host access, held until host_gnt
//   host_gnt, host_rvalid, host_rdata : issue pulse, read-return pulse and data
//   mem_en/we/addr/wdata, mem_rdata   : DMEM macro port (read data one cycle late)
module ama_riscv_dmem_arbiter
    import ama_riscv_dmem_arbiter_pkg::*;
#(
    parameter int AW            = 14,
    parameter int DW            = 32,
    parameter int HOST_MAX_WAIT = ARB_HOST_MAX_WAIT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            core_req,
    input  logic            core_we,
    input  logic [AW-1:0]   core_addr,
    input  logic [DW-1:0]   core_wdata,
    input  logic [DW/8-1:0] core_wmask,
    output logic [DW-1:0]   core_rdata,
    output logic            core_stall,
    input  logic            host_req,
    input  logic            host_we,
    input  logic [AW-1:0]   host_addr,
    input  logic [DW-1:0]   host_wdata,
    input  logic [DW/8-1:0] host_wmask,
    output logic            host_gnt,
    output logic            host_rvalid,
    output logic [DW-1:0]   host_rdata,
    output logic            mem_en,
    output logic [DW/8-1:0] mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int MW = DW / 8;

    logic     core_go;
    logic     host_sel;
    logic     rd_core;
    arb_sel_t sel;

`ifdef AMA_RISCV_DMEM_ARB_HOST_EN
    logic [7:0] wait_cnt;
    logic       rd_host;

    // Host wins when the core is idle, or when it has lost HOST_MAX_WAIT
    // contended cycles in a row. The counter is registered, so no comb loop.
    assign host_sel = host_req & (~core_req | (wait_cnt == 8'(HOST_MAX_WAIT)));
    assign core_go  = core_req & ~host_sel;

    ama_riscv_arb_wait_cnt #(
        .W   (8),
        .MAX (HOST_MAX_WAIT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (host_req & core_req & ~host_sel),
        .clr   (host_sel | ~host_req),
        .cnt   (wait_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_host <= 1'b0;
        else        rd_host <= host_sel & ~host_we;
    end

    // rst_n gating keeps every output at 0 while reset is asserted,
    // whatever the requesters are doing.
    assign host_gnt    = rst_n & host_sel;
    assign core_stall  = rst_n & core_req & host_sel;
    assign host_rvalid = rd_host;
    assign host_rdata  = rd_host ? mem_rdata : '0;
`else
    // Host port is inert in this build; fold its inputs into a sink.
    logic unused_host;
    assign unused_host = ^{host_req, host_we, host_addr, host_wdata, host_wmask};

    assign host_sel    = 1'b0;
    assign core_go     = core_req;
    assign host_gnt    = 1'b0;
    assign core_stall  = 1'b0;
    assign host_rvalid = 1'b0;
    assign host_rdata  = '0;
`endif

    assign sel = host_sel ? ARB_SEL_HOST : ARB_SEL_CORE;

    // Memory port: driven only for an issued access, zero otherwise.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n && (core_go || host_sel)) begin
            mem_en = 1'b1;
            case (sel)
                ARB_SEL_HOST: begin
                    mem_addr  = host_addr;
                    mem_wdata = host_wdata;
                    mem_we    = host_wmask & {MW{host_we}};
                end
                default: begin
                    mem_addr  = core_addr;
                    mem_wdata = core_wdata;
                    mem_we    = core_wmask & {MW{core_we}};
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_core <= 1'b0;
        else        rd_core <= core_go & ~core_we;
    end

    assign core_rdata = rd_core ? mem_rdata : '0;

endmodule

// File: tb/tb_ama_riscv_dmem_arbiter.sv
module tb_ama_riscv_dmem_arbiter;

    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int MW  = DW / 8;
    localparam int HMW = 8;
`ifdef AMA_RISCV_DMEM_ARB_HOST_EN
    localparam bit HEN = 1'b1;
`else
    localparam bit HEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_req, core_we, host_req, host_we;
    logic [AW-1:0] core_addr, host_addr, mem_addr;
    logic [DW-1:0] core_wdata, host_wdata, core_rdata, host_rdata, mem_wdata, mem_rdata;
    logic [MW-1:0] core_wmask, host_wmask, mem_we;
    logic          core_stall, host_gnt, host_rvalid, mem_en;

    ama_riscv_dmem_arbiter #(.AW(AW), .DW(DW), .HOST_MAX_WAIT(HMW)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_wmask(core_wmask),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_wmask(host_wmask),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory; returns garbage when not reading so that
    // ungated read data paths show up.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_en && mem_we == '0) begin
            mem_rdata <= mem[mem_addr[7:0]];
        end else begin
            mem_rdata <= $urandom;
            if (mem_en)
                for (int b = 0; b < MW; b++)
                    if (mem_we[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model: contended-loss count, pending read returns, memory image.
    int          vectors = 0, miscompares = 0;
    int          waited = 0;
    bit          pc_v = 0, ph_v = 0;
    logic [31:0] pc_d, ph_d;
    logic [31:0] ref_mem [0:255];
    bit          last_hs = 0, last_stall = 0, obs_gnt = 0, obs_en = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        waited = 0; pc_v = 0; ph_v = 0; last_hs = 0; last_stall = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_core_stall", core_stall, 0);
        chk("rst_host_gnt", host_gnt, 0);
        chk("rst_host_rvalid", host_rvalid, 0);
        chk("rst_host_rdata", host_rdata, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
    endtask

    task automatic check_cycle();
        bit          hs, cg;
        logic [3:0]  ewe;
        logic [13:0] ea;
        logic [31:0] ed;
        hs = HEN && host_req && (!core_req || waited == HMW);
        cg = core_req && !hs;
        if (hs) begin
            ea = host_addr; ed = host_wdata; ewe = host_we ? host_wmask : 4'b0;
        end else begin
            ea = core_addr; ed = core_wdata; ewe = core_we ? core_wmask : 4'b0;
        end
        chk("mem_en", mem_en, cg || hs);
        if (cg || hs) begin
            chk("mem_addr", mem_addr, ea);
            chk("mem_wdata", mem_wdata, ed);
            chk("mem_we", mem_we, ewe);
        end
        chk("core_stall", core_stall, core_req && hs);
        chk("host_gnt", host_gnt, hs);
        chk("host_rvalid", host_rvalid, ph_v);
        chk("host_rdata", host_rdata, ph_v ? ph_d : 32'h0);
        chk("core_rdata", core_rdata, pc_v ? pc_d : 32'h0);
        obs_gnt = host_gnt; obs_en = mem_en;
        last_hs = hs; last_stall = core_req && hs;
        pc_v = cg && !core_we; pc_d = ref_mem[core_addr[7:0]];
        ph_v = hs && !host_we; ph_d = ref_mem[host_addr[7:0]];
        if (cg && core_we) ref_mem[core_addr[7:0]] = merge(ref_mem[core_addr[7:0]], core_wdata, core_wmask);
        if (hs && host_we) ref_mem[host_addr[7:0]] = merge(ref_mem[host_addr[7:0]], host_wdata, host_wmask);
        if (HEN && host_req && !hs) waited++;
        else waited = 0;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic new_core(input int dens);
        core_req   = ($urandom_range(0, 99) < dens);
        core_we    = $urandom_range(0, 1);
        core_addr  = 14'($urandom_range(0, 255));
        core_wdata = $urandom;
        core_wmask = 4'($urandom_range(1, 15));
    endtask

    task automatic new_host(input int dens);
        host_req   = ($urandom_range(0, 99) < dens);
        host_we    = $urandom_range(0, 1);
        host_addr  = 14'($urandom_range(0, 255));
        host_wdata = $urandom;
        host_wmask = 4'($urandom_range(1, 15));
    endtask

    // Continuous core reads with one host read; returns the loop index of the grant.
    task automatic contention(input logic [13:0] ha, output int gnt_at);
        gnt_at = -1;
        host_req = 1; host_we = 0; host_addr = ha;
        for (int i = 0; i < 12; i++) begin
            if (!last_stall) begin new_core(100); core_we = 0; end
            if (last_hs) host_req = 0;
            step();
            if (obs_gnt && gnt_at < 0) gnt_at = i;
        end
        host_req = 0;
    endtask

    initial begin
        int gnt_at, gnts, ens;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[8'h10] = 32'hDEADBEEF;
        ref_mem[8'h10] = 32'hDEADBEEF;

        // Reset with both requesters active: everything must stay at 0.
        core_req = 1; core_we = 0; core_addr = 14'h05; core_wdata = 32'h0; core_wmask = 4'hF;
        host_req = 1; host_we = 0; host_addr = 14'h07; host_wdata = 32'h0; host_wmask = 4'hF;
        #2 check_reset_outputs();
        @(posedge clk); #3 check_reset_outputs();
        @(posedge clk); #1 rst_n = 1;
        step();                          // core wins first cycle after release
        core_req = 0;
        step();                          // host served while core idles
        host_req = 0;

        // Core read of 0x10, host idle.
        core_req = 1; core_we = 0; core_addr = 14'h10;
        step();
        chk("dir_core_rdata", core_rdata, 32'hDEADBEEF);
        chk("dir_core_host_rvalid", host_rvalid, 0);
        core_req = 0;

        // Host write of 0x20, core idle.
        host_req = 1; host_we = 1; host_addr = 14'h20; host_wdata = 32'h12345678; host_wmask = 4'b0011;
        #1;
        chk("dir_host_gnt", host_gnt, HEN);
        chk("dir_host_mem_we", mem_we, HEN ? 4'b0011 : 4'b0000);
        step();
        chk("dir_host_wr_rvalid", host_rvalid, 0);
        host_req = 0;
        step();

        // Worst-case host latency under continuous core traffic.
        contention(14'h30, gnt_at);
        chk("contention_gnt_cycle", gnt_at, HEN ? HMW : -1);
        core_req = 0;
        step();

        // Reset between host read issue and its return: return is dropped.
        host_req = 1; host_we = 0; host_addr = 14'h40;
        @(negedge clk);
        check_cycle();
        #1 rst_n = 0;
        model_reset();
        #1 check_reset_outputs();
        @(posedge clk); #1;
        check_reset_outputs();
        rst_n = 1;
        host_req = 0;
        step();
        contention(14'h40, gnt_at);      // full wait again: counter restarted at 0
        chk("post_rst_gnt_cycle", gnt_at, HEN ? HMW : -1);
        core_req = 0;

        // Host requesting with core idle for 20 cycles.
        host_req = 1; host_we = 0; host_addr = 14'h50;
        gnts = 0; ens = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            gnts += int'(obs_gnt);
            ens  += int'(obs_en);
        end
        chk("idle_host_gnts", gnts, HEN ? 20 : 0);
        chk("idle_host_mem_en", ens, HEN ? 20 : 0);
        host_req = 0;

        // Random traffic obeying the hold rules of both requesters.
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) new_core(i < 200 ? 60 : 95);
            if (!host_req || last_hs) new_host(40);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
